// File: rtl/cache_port_arbiter_pkg.sv
// Shared definitions for the two-port cache arbiter: FSM encodings, port ids
// and the read-latency counter type.
package cache_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Wide enough to hold the largest legal read latency (8).
  localparam int unsigned CNT_W = 4;
  typedef logic [CNT_W-1:0] lat_cnt_t;

endpackage

// File: rtl/cache_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins; on contention the
// port that did not win last time is granted.
module cache_arb_rr
  import cache_port_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == PORT_LS) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares a single-port cache between instruction fetch (port 0) and load/store
// (port 1): round-robin grant, one outstanding access, fixed read latency.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [DATA_W-1:0] cache_data,
  output logic              cache_wr,
  input  logic [DATA_W-1:0] cache_q
);

  logic [1:0]        state;
  logic              last_grant;
  logic              lat_port;
  logic              lat_wr;
  lat_cnt_t          lat_cnt;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  logic [1:0]        grant;
  logic              idle;
  logic              accept;
  logic              sel;

  cache_arb_rr u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign idle       = (state == ST_IDLE) && !rst;
  assign req0_ready = idle && grant[0];
  assign req1_ready = idle && grant[1];
  assign accept     = req0_ready || req1_ready;
  assign sel        = grant[1] ? PORT_LS : PORT_IF;

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data;
  assign rsp1_data  = rsp_data;

  // The cache_addr/cache_data registers double as the request latch: they are
  // loaded on acceptance so the cache sees them during ISSUE and they hold after.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_LS;
      lat_port   <= PORT_IF;
      lat_wr     <= 1'b0;
      lat_cnt    <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      cache_addr <= '0;
      cache_data <= '0;
      cache_wr   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_port   <= sel;
            lat_wr     <= sel ? req1_wr : req0_wr;
            cache_wr   <= sel ? req1_wr : req0_wr;
            cache_addr <= sel ? req1_addr : req0_addr;
            cache_data <= sel ? req1_data : req0_data;
            last_grant <= sel;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cache_wr <= 1'b0;
          if (lat_wr) begin
            rsp_data            <= '0;
            rsp_valid[lat_port] <= 1'b1;
            state               <= ST_RESP;
          end else begin
            lat_cnt <= CNT_W'(RD_LAT);
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Count reaches 1 in the cycle the cache presents valid q.
          if (lat_cnt == CNT_W'(1)) begin
            rsp_data            <= cache_q;
            rsp_valid[lat_port] <= 1'b1;
            state               <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Randomized and directed checks of cache_port_arbiter against a cycle-schedule
// reference model with its own cache memory.
module tb_cache_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0_valid = 1'b0, req0_wr = 1'b0, req0_ready;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          rsp0_valid;
  logic [DW-1:0] rsp0_data;
  logic          req1_valid = 1'b0, req1_wr = 1'b0, req1_ready;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          rsp1_valid;
  logic [DW-1:0] rsp1_data;
  logic [AW-1:0] cache_addr;
  logic [DW-1:0] cache_data;
  logic          cache_wr;
  logic [DW-1:0] cache_q = '0;

  always #5 clk = ~clk;

  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_wr    (req0_wr),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_wr    (req1_wr),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .cache_addr (cache_addr),
    .cache_data (cache_data),
    .cache_wr   (cache_wr),
    .cache_q    (cache_q)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          cyc = 0;

  // Reference model: one pending access described by its schedule.
  bit          en = 1'b0;
  bit          pend = 1'b0;
  int          issue_cyc, resp_cyc, free_at = 0;
  bit          p_port, p_wr;
  logic [31:0] p_addr, p_data, p_rdata;
  bit          last = 1'b1;
  logic [31:0] last_caddr = '0, last_cdata = '0;
  logic [31:0] obs_addr = '0;
  logic [31:0] ref_mem [16];
  logic [31:0] cache_mem [16];
  bit          acc0, acc1, obs_acc0, obs_acc1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int idx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic step(input bit v0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                      input bit v1, input bit w1, input logic [31:0] a1, input logic [31:0] d1,
                      input bit r);
    bit can, g0, g1, at_resp;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_data = d1;
    if (pend && !p_wr && cyc == issue_cyc + int'(LAT)) cache_q = cache_mem[idx(obs_addr)];
    else cache_q = $urandom;
    @(negedge clk);
    obs_acc0 = req0_valid && req0_ready;
    obs_acc1 = req1_valid && req1_ready;
    can = !r && cyc >= free_at;
    g0 = can && v0 && (!v1 || last);
    g1 = can && v1 && (!v0 || !last);
    at_resp = pend && cyc == resp_cyc;
    if (en) begin
      check("ready0", 64'(req0_ready), 64'(g0));
      check("ready1", 64'(req1_ready), 64'(g1));
      check("cache_wr", 64'(cache_wr), 64'(pend && cyc == issue_cyc && p_wr));
      check("cache_addr", 64'(cache_addr), 64'((pend && cyc == issue_cyc) ? p_addr : last_caddr));
      check("cache_data", 64'(cache_data), 64'((pend && cyc == issue_cyc) ? p_data : last_cdata));
      check("rsp0_valid", 64'(rsp0_valid), 64'(at_resp && !p_port));
      check("rsp1_valid", 64'(rsp1_valid), 64'(at_resp && p_port));
      if (at_resp)
        check(p_port ? "rsp1_data" : "rsp0_data", 64'(p_port ? rsp1_data : rsp0_data),
              64'(p_wr ? 32'h0 : p_rdata));
    end
    if (cache_wr) cache_mem[idx(cache_addr)] = cache_data;
    if (pend && cyc == issue_cyc) begin
      obs_addr   = cache_addr;
      last_caddr = p_addr;
      last_cdata = p_data;
      if (p_wr) ref_mem[idx(p_addr)] = p_data;
      else      p_rdata = ref_mem[idx(p_addr)];
    end
    if (at_resp) pend = 1'b0;
    acc0 = g0;
    acc1 = g1;
    if (g0 || g1) begin
      pend      = 1'b1;
      p_port    = g1;
      p_wr      = g1 ? w1 : w0;
      p_addr    = g1 ? a1 : a0;
      p_data    = g1 ? d1 : d0;
      issue_cyc = cyc + 1;
      resp_cyc  = cyc + 2 + (p_wr ? 0 : int'(LAT));
      free_at   = resp_cyc + 1;
      last      = g1;
    end
    if (r) begin
      pend = 1'b0; last = 1'b1; last_caddr = '0; last_cdata = '0;
      free_at = cyc + 1;
      en = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // Holds valid on one port until accepted, bounded.
  task automatic req(input bit port, input bit w, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    do begin
      if (port) step(0, 0, 0, 0, 1, w, a, d, 0);
      else      step(1, w, a, d, 0, 0, 0, 0, 0);
      n++;
    end while (!(port ? obs_acc1 : obs_acc0) && n < 40);
    check("req_accepted", 64'(port ? obs_acc1 : obs_acc0), 64'd1);
  endtask

  initial begin
    int q[$];
    int acc_cyc[$];
    int k, ta, seen_cyc;
    logic [31:0] seen_data;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = $urandom;
      cache_mem[i] = ref_mem[i];
    end

    // Reset, then write/read on port 0.
    do_reset();
    idle(2);
    req(0, 1, 32'h00, 32'h01);
    req(0, 0, 32'h00, 32'h00);
    idle(LAT + 3);

    // Both ports valid continuously: grants alternate starting with port 0.
    do_reset();
    for (int i = 0; i < 4 * int'(LAT + 3); i++) begin
      step(1, 0, 32'h04, $urandom, 1, 0, 32'h08, $urandom, 0);
      if (obs_acc0) q.push_back(0);
      if (obs_acc1) q.push_back(1);
    end
    check("alt_count", 64'(q.size()), 64'd4);
    for (int i = 0; i < q.size() && i < 4; i++) check("alt_order", 64'(q[i]), 64'(i % 2));
    idle(LAT + 3);

    // Port 1 alone, back-to-back reads.
    k = 0;
    for (int i = 0; i < 4 * int'(LAT + 3); i++) begin
      step(0, 0, 0, 0, 1, 0, 32'h20 + 32'(4 * k), 0, 0);
      if (obs_acc1) begin acc_cyc.push_back(cyc); k++; end
    end
    check("p1_count", 64'(acc_cyc.size()), 64'd4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("p1_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(LAT + 3));
    idle(LAT + 3);

    // Reset during WAIT drops the response; next request is served.
    req(0, 0, 32'h0C, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(LAT + 4);
    req(0, 0, 32'h0C, 0);
    idle(LAT + 3);

    // Write then read 0x10: exact read-response latency and data.
    req(1, 1, 32'h10, 32'hDEADBEEF);
    req(1, 0, 32'h10, 0);
    ta = cyc;
    seen_cyc = -1;
    seen_data = '0;
    for (int i = 0; i < int'(LAT) + 4; i++) begin
      idle(1);
      if (rsp1_valid && seen_cyc < 0) begin seen_cyc = cyc; seen_data = rsp1_data; end
    end
    check("lat_cycles", 64'(seen_cyc - ta), 64'(LAT + 2));
    check("lat_data", 64'(seen_data), 64'h0000_0000_DEAD_BEEF);

    // Random traffic with occasional resets.
    repeat (1500) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
           $urandom_range(0, 199) == 0);
    end
    idle(LAT + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
